// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN output-stationary MAC array: buffers A/B, then streams skewed lanes.
// Start-to-done is 3N edges; every output is registered; there is no backpressure, and writes or starts made while running are rejected.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_row,
  input  logic [AW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  output logic            wr_err,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            arr_rst_n,
  output logic [N*DW-1:0] west_out,
  output logic [N*DW-1:0] north_out
);

  localparam int SW = AW + 2;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   a_d [N][N];
  logic [DW-1:0]   b_q [N][N];
  logic [DW-1:0]   b_d [N][N];
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            wr_err_q, wr_err_d;
  logic            arr_rst_n_q, arr_rst_n_d;
  logic [N*DW-1:0] west_q, west_d;
  logic [N*DW-1:0] north_q, north_d;
  logic [AW-1:0]   idx;
  int              st;

  assign wr_err    = wr_err_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign arr_rst_n = arr_rst_n_q;
  assign west_out  = west_q;
  assign north_out = north_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (wr_en) begin
          if (wr_sel) b_d[wr_row][wr_col] = wr_data;
          else        a_d[wr_row][wr_col] = wr_data;
        end
        if (start) begin
          state_d = CLEAR;
          step_d  = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        step_d  = '0;
      end
      STREAM: begin
        if (step_q == SW'(2*N-2)) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = (&step_q) ? step_q : step_q + SW'(1);
        end
      end
      DRAIN: begin
        if (step_q == SW'(N-1)) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = (&step_q) ? step_q : step_q + SW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wr_err_d    = wr_en && (state_q != IDLE);
    busy_d      = (state_d == CLEAR) || (state_d == STREAM) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    arr_rst_n_d = (state_d != CLEAR);
  end

  // Lanes are computed for the step about to become visible, so they line up with the registered state.
  always_comb begin
    west_d  = '0;
    north_d = '0;
    idx     = '0;
    st      = int'(step_d);
    if (state_d == STREAM) begin
      for (int i = 0; i < N; i++) begin
        if (st >= i && st < i + N) begin
          idx                  = AW'(st - i);
          west_d[i*DW +: DW]   = a_q[i][idx];
          north_d[i*DW +: DW]  = b_q[idx][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_err_q    <= 1'b0;
      arr_rst_n_q <= 1'b0;
      west_q      <= '0;
      north_q     <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_err_q    <= wr_err_d;
      arr_rst_n_q <= arr_rst_n_d;
      west_q      <= west_d;
      north_q     <= north_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives the feeder into a behavioural MAC array and checks lanes, handshakes and C = A*B.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int LW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_sel = 1'b0;
  logic [AW-1:0] wr_row = '0;
  logic [AW-1:0] wr_col = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          wr_err, busy, done, arr_rst_n;
  logic [LW-1:0] west_out, north_out;

  always #5 clk = ~clk;

  systolic_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .wr_err(wr_err), .start(start),
    .busy(busy), .done(done), .arr_rst_n(arr_rst_n),
    .west_out(west_out), .north_out(north_out)
  );

  // Behavioural output-stationary array fed by the DUT.
  logic [15:0]   acc [N][N];
  logic [DW-1:0] hr [N][N];
  logic [DW-1:0] vr [N][N];
  logic [DW-1:0] pw [N][N];
  logic [DW-1:0] pn [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      pw[i][0] = west_out[i*DW +: DW];
      pn[0][i] = north_out[i*DW +: DW];
      for (int j = 1; j < N; j++) begin
        pw[i][j] = hr[i][j-1];
        pn[j][i] = vr[j-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!arr_rst_n) begin
          acc[i][j] <= '0;
          hr[i][j]  <= '0;
          vr[i][j]  <= '0;
        end else begin
          acc[i][j] <= acc[i][j] + 16'(pw[i][j]) * 16'(pn[i][j]);
          hr[i][j]  <= pw[i][j];
          vr[i][j]  <= pn[i][j];
        end
      end
    end
  end

  // Reference copy of the operand buffers.
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];

  int vecs = 0;
  int miscompares = 0;
  int cur_c = 0;

  typedef struct {
    logic [DW-1:0] w2;
    logic [DW-1:0] n1;
    logic          arr;
    logic          bsy;
    logic          dn;
  } vec_t;
  vec_t tbl [3*N+1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got 'h%0h, expected 'h%0h", nm, cur_c, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = '0;
        mb[r][c] = '0;
      end
  endtask

  task automatic write_el(input logic sel, input int r, input int c, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = AW'(r); wr_col = AW'(c); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) mb[r][c] = d; else ma[r][c] = d;
    chk("wr_err_idle", 64'(wr_err), 64'd0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, DW'($urandom_range(0, 255)));
        write_el(1'b1, r, c, DW'($urandom_range(0, 255)));
      end
  endtask

  function automatic logic [LW-1:0] exp_west(input int t);
    logic [LW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*DW +: DW] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_north(input int t);
    logic [LW-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*DW +: DW] = mb[t-j][j];
    return v;
  endfunction

  task automatic check_product();
    int s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += int'(ma[i][k]) * int'(mb[k][j]);
        chk("c_matrix", 64'(acc[i][j]), 64'(s[15:0]));
      end
  endtask

  // One multiply. Cycle c counts edges after the start edge. Negative arguments disable the perturbation.
  task automatic do_run(input int wr_at, input int st1, input int st2, input int rst_at, input bit same_wr);
    int r, c;
    if (same_wr) begin
      r = $urandom_range(0, N-1); c = $urandom_range(0, N-1);
      wr_en = 1'b1; wr_sel = 1'($urandom_range(0, 1)); wr_row = AW'(r); wr_col = AW'(c);
      wr_data = DW'($urandom_range(0, 255));
      if (wr_sel) mb[r][c] = wr_data; else ma[r][c] = wr_data;
    end
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int cy = 0; cy <= 3*N; cy++) begin
      cur_c = cy;
      chk("arr_rst_n", 64'(arr_rst_n), 64'(cy != 0));
      chk("busy", 64'(busy), 64'(cy < 3*N));
      chk("done", 64'(done), 64'(cy == 3*N));
      chk("wr_err", 64'(wr_err), 64'(wr_at >= 0 && cy == wr_at + 1));
      chk("west_out", 64'(west_out), (cy >= 1 && cy <= 2*N-1) ? 64'(exp_west(cy-1)) : 64'd0);
      chk("north_out", 64'(north_out), (cy >= 1 && cy <= 2*N-1) ? 64'(exp_north(cy-1)) : 64'd0);
      if (cy == 3*N) break;
      if (cy == wr_at) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'd9;
      end
      if (cy == st1 || cy == st2) start = 1'b1;
      if (cy == rst_at) rst = 1'b0;
      tick();
      wr_en = 1'b0; start = 1'b0;
      if (cy == rst_at) begin
        cur_c = cy + 1;
        chk("rst_lanes", 64'({west_out, north_out}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_arr_rst_n", 64'(arr_rst_n), 64'd0);
        clear_model();
        rst = 1'b1;
        tick();
        chk("post_rst_arr_rst_n", 64'(arr_rst_n), 64'd1);
        chk("post_rst_done", 64'(done), 64'd0);
        return;
      end
    end
    check_product();
    tick();
    cur_c = 3*N + 1;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_arr_rst_n", 64'(arr_rst_n), 64'd1);
  endtask

  initial begin
    clear_model();

    // Reset held for five cycles, then released.
    for (int k = 0; k < 5; k++) begin
      tick();
      cur_c = k;
      chk("reset_lanes", 64'({west_out, north_out}), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_arr_rst_n", 64'(arr_rst_n), 64'd0);
    end
    rst = 1'b1;
    tick();
    chk("idle_arr_rst_n_after_reset", 64'(arr_rst_n), 64'd1);
    chk("idle_wr_err", 64'(wr_err), 64'd0);

    // Identity A, B[r][c] = 4r+c+1, checked against a fixed vector table.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, (r == c) ? 8'd1 : 8'd0);
        write_el(1'b1, r, c, DW'(4*r + c + 1));
      end
    tbl[0] = '{w2: 8'd0, n1: 8'd0, arr: 1'b0, bsy: 1'b1, dn: 1'b0};
    tbl[1] = '{w2: 8'd0, n1: 8'd0,  arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[2] = '{w2: 8'd0, n1: 8'd2,  arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[3] = '{w2: 8'd0, n1: 8'd6,  arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[4] = '{w2: 8'd0, n1: 8'd10, arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[5] = '{w2: 8'd1, n1: 8'd14, arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[6] = '{w2: 8'd0, n1: 8'd0,  arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[7] = '{w2: 8'd0, n1: 8'd0,  arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    for (int k = 8; k < 3*N; k++) tbl[k] = '{w2: 8'd0, n1: 8'd0, arr: 1'b1, bsy: 1'b1, dn: 1'b0};
    tbl[3*N] = '{w2: 8'd0, n1: 8'd0, arr: 1'b1, bsy: 1'b0, dn: 1'b1};
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 3*N; k++) begin
      cur_c = k;
      chk("tbl_west2", 64'(west_out[2*DW +: DW]), 64'(tbl[k].w2));
      chk("tbl_north1", 64'(north_out[1*DW +: DW]), 64'(tbl[k].n1));
      chk("tbl_arr_rst_n", 64'(arr_rst_n), 64'(tbl[k].arr));
      chk("tbl_busy", 64'(busy), 64'(tbl[k].bsy));
      chk("tbl_done", 64'(done), 64'(tbl[k].dn));
      if (k < 3*N) tick();
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk("c_equals_b", 64'(acc[i][j]), 64'(4*i + j + 1));
    tick();

    // All-255 operands: accumulator wraps to 63492.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, 8'd255);
        write_el(1'b1, r, c, 8'd255);
      end
    do_run(-1, -1, -1, -1, 1'b0);
    chk("c_255_wrap", 64'(acc[2][1]), 64'd63492);

    // Write during STREAM is rejected; a repeat run gives the same product.
    fill_random();
    do_run(3, -1, -1, -1, 1'b0);
    do_run(-1, -1, -1, -1, 1'b0);

    // Starts during STREAM and DRAIN are ignored.
    do_run(-1, 4, 2*N+1, -1, 1'b0);

    // Reset during step 4, then a sparse rewrite relies on cleared buffers.
    do_run(-1, -1, -1, 5, 1'b0);
    write_el(1'b0, 1, 2, 8'd7);
    write_el(1'b1, 2, 3, 8'd5);
    do_run(-1, -1, -1, -1, 1'b0);

    // Randomised runs, some with a write landing on the start edge.
    for (int n = 0; n < 4; n++) begin
      fill_random();
      do_run(-1, -1, -1, -1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
